hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: RAW/load-use detection, branch flush,
// data-memory wait FSM with timeout flag and saturating stall counter.
module hazard_controller (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  src1_i,
    input  logic [3:0]  src2_i,
    input  logic        two_src_i,
    input  logic        exe_wb_en_i,
    input  logic        exe_mem_r_en_i,
    input  logic [3:0]  exe_dest_i,
    input  logic        mem_wb_en_i,
    input  logic [3:0]  mem_dest_i,
    input  logic        fwd_en_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        hazard_o,
    output logic        freeze_if_o,
    output logic        freeze_id_o,
    output logic        freeze_mem_o,
    output logic        flush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_count_o,
    output logic        mem_timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;

    logic exe_m1, exe_m2, mem_m1, mem_m2;
    logic raw_hazard;
    logic freeze_mem, hazard, flush, freeze;

    assign exe_m1 = (exe_dest_i == src1_i);
    assign exe_m2 = two_src_i & (exe_dest_i == src2_i);
    assign mem_m1 = (mem_dest_i == src1_i);
    assign mem_m2 = two_src_i & (mem_dest_i == src2_i);

    // With forwarding only a load in EXE cannot be bypassed in time
    assign raw_hazard = fwd_en_i
        ? (exe_mem_r_en_i & (exe_m1 | exe_m2))
        : ((exe_wb_en_i & (exe_m1 | exe_m2)) |
           (mem_wb_en_i & (mem_m1 | mem_m2)));

    always_comb begin
        freeze_mem = 1'b0;
        hazard     = 1'b0;
        flush      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                freeze_mem = mem_req_i & ~mem_ready_i;
                hazard     = raw_hazard & ~branch_taken_i & ~freeze_mem;
                flush      = branch_taken_i & ~freeze_mem;
                if (freeze_mem) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (branch_taken_i) begin
                    state_d = FLUSH;
                end
            end
            MEM_WAIT: begin
                freeze_mem = ~mem_ready_i;
                flush      = branch_taken_i & mem_ready_i;
                if (wait_cnt_q != 8'hFF)
                    wait_cnt_d = wait_cnt_q + 8'd1;
                if (mem_ready_i)
                    state_d = branch_taken_i ? FLUSH : RUN;
            end
            FLUSH: begin
                flush   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign freeze = hazard | freeze_mem;

    always_comb begin
        stall_d   = stall_q;
        timeout_d = timeout_q;
        if (freeze && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        if (state_q == MEM_WAIT && wait_cnt_d == 8'hFF)
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            stall_q    <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    // Control outputs are held inactive for the whole reset assertion
    assign hazard_o      = rst_ni & hazard;
    assign freeze_mem_o  = rst_ni & freeze_mem;
    assign freeze_if_o   = rst_ni & freeze;
    assign freeze_id_o   = rst_ni & freeze;
    assign flush_o       = rst_ni & flush;
    assign state_o       = state_q;
    assign stall_count_o = stall_q;
    assign mem_timeout_o = timeout_q;

endmodule
